mtl_timing_engine: RTL and testbench
====================================

MTL_TIMING_ENGINE -- requirements
Module: mtl_timing_engine

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 210, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 1, HSYNC pulse width in clocks.
REQ-004 SHALL have parameter H_BP, default 45, horizontal back porch in clocks.
REQ-005 SHALL have parameters V_ACTIVE 480, V_FP 22, V_SYNC 1, V_BP 22, vertical equivalents in lines.
REQ-006 SHALL have parameter COLOR_W, default 8, bits per colour channel.
REQ-007 SHALL have parameter REQ_LEAD, default 2, range 1..8, clocks oREQ precedes pixel sampling.
REQ-008 SHALL have one clock and an asynchronous, active-high reset: iCLK input 1 (pixel clock) and iRST input 1 (asynchronous, active-high reset).
REQ-009 SHALL have iMODE input 2: 0 blank, 1 solid, 2 colour bars, 3 stream.
REQ-010 SHALL have iSOLID_R/G/B inputs COLOR_W each, the solid-mode colour.
REQ-011 SHALL have iPIX_R/G/B inputs COLOR_W each, the stream pixel; iPIX_VALID input 1 marks them valid.
REQ-012 SHALL have iCLR_ERR input 1, which clears oUNDERFLOW.
REQ-013 SHALL have oREQ output 1, a stream pixel request.
REQ-014 SHALL have outputs oHD, oVD (1 each, active-low syncs) and oDE (1, data enable).
REQ-015 SHALL have oLCD_R/G/B outputs COLOR_W each, the pixel colour.
REQ-016 SHALL have oX output 11 and oY output 10, the raw counters, unregistered.
REQ-017 SHALL have oNewFrame, oEndFrame and oUNDERFLOW outputs, 1 bit each.

Function
REQ-018 SHALL set H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP (default 1056) and V_TOTAL likewise (default 525).
REQ-019 SHALL advance x 0..H_TOTAL-1 every clock; x wraps to 0; y increments on the wrap and returns to 0 after V_TOTAL-1.
REQ-020 SHALL define hsync_n=(x>=H_SYNC), vsync_n=(y>=V_SYNC), and active=(H_SYNC+H_BP<=x<H_SYNC+H_BP+H_ACTIVE) AND (V_SYNC+V_BP<=y<V_SYNC+V_BP+V_ACTIVE).
REQ-021 SHALL register oHD, oVD, oDE and oLCD_* from the counter-cycle values: 1-clock latency, all mutually aligned.
REQ-022 SHALL drive oLCD_* to 0 whenever active is 0.
REQ-023 SHALL pulse oNewFrame (combinational) for 1 clock at x=0,y=0 and oEndFrame at the last active pixel of the last active line.
REQ-024 SHALL sample iMODE into a frame-mode register only at x=0,y=0; mid-frame iMODE changes are ignored until the next frame.
REQ-025 SHALL, in mode 0, output black; in mode 1, output iSOLID_* (sampled live each pixel).
REQ-026 SHALL, in mode 2, output 8 bars of width H_ACTIVE/8 (integer), in order white, yellow, cyan, green, magenta, red, blue, black, each channel all-ones or zero; the last bar absorbs any remainder.
REQ-027 SHALL, in mode 3, assert oREQ exactly when the pixel at counter position (x+REQ_LEAD, with line/frame wrap) is active; one request per active pixel, none otherwise.
REQ-028 SHALL, in mode 3, sample iPIX_* on the active cycle REQ_LEAD clocks after the matching oREQ; iPIX_VALID=0 at that cycle outputs 0 and sets oUNDERFLOW.
REQ-029 SHALL assert oREQ early on the last REQ_LEAD clocks of a frame when that frame's latched mode is stream and iMODE is 3 (the predicted next-frame mode).
REQ-030 SHALL make oUNDERFLOW sticky: set priority over iCLR_ERR in the same cycle.
REQ-031 SHALL keep oREQ 0 in modes 0-2 and ignore iPIX_* there.

Reset
REQ-032 SHALL, while iRST=1, asynchronously force x=0, y=0, frame mode=0, oREQ=0, oDE=0, oLCD_*=0, oUNDERFLOW=0, oHD=1, oVD=1.
REQ-033 SHALL, on the first clock after iRST falls, count from x=0,y=0 and pulse oNewFrame; mid-frame reset aborts the frame with no partial-line output.

Verification
REQ-034 SHALL verify, with defaults, mode 0 for 2 frames -> oHD low 1 clk per 1056, oVD low 1056 clks per 554400, oDE high 800x480 clks per frame.
REQ-035 SHALL verify mode 2 -> line pixel 0 = (FF,FF,FF), pixel 100 = (FF,FF,00), pixel 799 = (00,00,00).
REQ-036 SHALL verify mode 3 with a source returning x-derived data after REQ_LEAD=2 -> 384000 oREQ pulses per frame, output matches source, oUNDERFLOW=0.
REQ-037 SHALL verify mode 3 with iPIX_VALID dropped for one sample -> that pixel black, oUNDERFLOW=1 until iCLR_ERR; with simultaneous set and clear -> remains 1.
REQ-038 SHALL verify iMODE switched 1->2 at mid-frame y=200 -> solid colour until frame end, bars from the next oNewFrame.
REQ-039 SHALL verify a small-timing configuration (H_ACTIVE=8, H_FP=2, H_SYNC=1, H_BP=1, V 4/1/1/1) -> H_TOTAL=12, V_TOTAL=7, wrap and the oEndFrame pulse at x=9,y=5.

Source files
------------

// File: rtl/mtl_timing_engine_if.sv
// mtl_timing_engine_if: pixel-source, control and raster-output bundle of the timing engine.
// Ports: master = engine side (takes i* controls/pixels, drives o* raster/status);
//        slave  = environment side (drives i*, observes o*).
interface mtl_timing_engine_if #(
  parameter int COLOR_W = 8
);
  // Controls and pixel source
  logic [1:0]         iMODE;
  logic [COLOR_W-1:0] iSOLID_R;
  logic [COLOR_W-1:0] iSOLID_G;
  logic [COLOR_W-1:0] iSOLID_B;
  logic [COLOR_W-1:0] iPIX_R;
  logic [COLOR_W-1:0] iPIX_G;
  logic [COLOR_W-1:0] iPIX_B;
  logic               iPIX_VALID;
  logic               iCLR_ERR;
  // Raster outputs and status
  logic               oREQ;
  logic               oHD;
  logic               oVD;
  logic               oDE;
  logic [COLOR_W-1:0] oLCD_R;
  logic [COLOR_W-1:0] oLCD_G;
  logic [COLOR_W-1:0] oLCD_B;
  logic [10:0]        oX;
  logic [9:0]         oY;
  logic               oNewFrame;
  logic               oEndFrame;
  logic               oUNDERFLOW;

  modport master (
    input  iMODE, iSOLID_R, iSOLID_G, iSOLID_B,
    input  iPIX_R, iPIX_G, iPIX_B, iPIX_VALID, iCLR_ERR,
    output oREQ, oHD, oVD, oDE, oLCD_R, oLCD_G, oLCD_B,
    output oX, oY, oNewFrame, oEndFrame, oUNDERFLOW
  );

  modport slave (
    output iMODE, iSOLID_R, iSOLID_G, iSOLID_B,
    output iPIX_R, iPIX_G, iPIX_B, iPIX_VALID, iCLR_ERR,
    input  oREQ, oHD, oVD, oDE, oLCD_R, oLCD_G, oLCD_B,
    input  oX, oY, oNewFrame, oEndFrame, oUNDERFLOW
  );
endinterface

// File: rtl/mtl_timing_engine.sv
// mtl_timing_engine: free-running raster timing generator with blank, solid, colour-bar
//   and pulled-stream pixel sources; frame mode is latched at x=0,y=0.
// Latency: oHD/oVD/oDE/oLCD_*/oUNDERFLOW registered 1 clk after the raw counter (oX/oY);
//   oREQ/oNewFrame/oEndFrame are combinational from the counter.
// Backpressure: none, the raster never stalls; stream pixels are pulled with oREQ
//   REQ_LEAD clks ahead, a pixel missing at its slot is blanked and latched in oUNDERFLOW.
// Ports: iCLK pixel clock, iRST async active-high reset, bus = mtl_timing_engine_if.master.
module mtl_timing_engine #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 210,
  parameter int H_SYNC   = 1,
  parameter int H_BP     = 45,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 22,
  parameter int V_SYNC   = 1,
  parameter int V_BP     = 22,
  parameter int COLOR_W  = 8,
  parameter int REQ_LEAD = 2
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  mtl_timing_engine_if.master   bus
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [10:0] X_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] X_HS   = 11'(H_SYNC);
  localparam logic [9:0]  Y_VS   = 10'(V_SYNC);
  localparam logic [10:0] X_ACT0 = 11'(H_SYNC + H_BP);
  localparam logic [10:0] X_ACT1 = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  Y_ACT0 = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  Y_ACT1 = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [10:0] X_EF   = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0]  Y_EF   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
  localparam logic [11:0] LEAD_W    = 12'(REQ_LEAD);

  localparam logic [1:0] MODE_BLANK  = 2'd0;
  localparam logic [1:0] MODE_SOLID  = 2'd1;
  localparam logic [1:0] MODE_BARS   = 2'd2;
  localparam logic [1:0] MODE_STREAM = 2'd3;

  function automatic logic is_active(input logic [10:0] x, input logic [9:0] y);
    return (x >= X_ACT0) && (x < X_ACT1) && (y >= Y_ACT0) && (y < Y_ACT1);
  endfunction

  // State
  logic [10:0]        x_q, x_d;
  logic [9:0]         y_q, y_d;
  logic [1:0]         mode_q, mode_d;
  logic               hd_q, hd_d, vd_q, vd_d, de_q, de_d, uf_q, uf_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  // Combinational helpers
  logic        frame_start, active, uf_set;
  logic [11:0] la_sum;
  logic [10:0] la_x;
  logic [9:0]  la_y;
  logic        la_next_frame;
  logic [10:0] hx;
  logic [2:0]  bar_idx, bar_rgb;

  assign frame_start = (x_q == '0) && (y_q == '0);
  assign active      = is_active(x_q, y_q);

  // Raster counters and frame-mode latch
  always_comb begin
    x_d    = x_q + 11'd1;
    y_d    = y_q;
    mode_d = frame_start ? bus.iMODE : mode_q;
    if (x_q == X_LAST) begin
      x_d = '0;
      y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
    end
  end

  // Counter position REQ_LEAD clocks ahead, wrapping across line and frame.
  always_comb begin
    la_sum        = {1'b0, x_q} + LEAD_W;
    la_x          = la_sum[10:0];
    la_y          = y_q;
    la_next_frame = 1'b0;
    if (la_sum >= H_TOTAL_W) begin
      la_x = 11'(la_sum - H_TOTAL_W);
      if (y_q == Y_LAST) begin
        la_y          = '0;
        la_next_frame = 1'b1;
      end else begin
        la_y = y_q + 10'd1;
      end
    end
  end

  // Bar index: count of bar boundaries already passed, capped at 7 so the
  // last bar absorbs the H_ACTIVE remainder.
  always_comb begin
    hx      = x_q - X_ACT0;
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hx >= 11'(k * BAR_W)) bar_idx = 3'(k);
    end
    case (bar_idx)
      3'd0:    bar_rgb = 3'b111; // white
      3'd1:    bar_rgb = 3'b110; // yellow
      3'd2:    bar_rgb = 3'b011; // cyan
      3'd3:    bar_rgb = 3'b010; // green
      3'd4:    bar_rgb = 3'b101; // magenta
      3'd5:    bar_rgb = 3'b100; // red
      3'd6:    bar_rgb = 3'b001; // blue
      default: bar_rgb = 3'b000; // black
    endcase
  end

  // Pixel / sync selection for the current counter cycle, registered below.
  always_comb begin
    hd_d   = (x_q >= X_HS);
    vd_d   = (y_q >= Y_VS);
    de_d   = active;
    r_d    = '0;
    g_d    = '0;
    b_d    = '0;
    uf_set = 1'b0;
    if (active) begin
      case (mode_q)
        MODE_SOLID: begin
          r_d = bus.iSOLID_R;
          g_d = bus.iSOLID_G;
          b_d = bus.iSOLID_B;
        end
        MODE_BARS: begin
          r_d = {COLOR_W{bar_rgb[2]}};
          g_d = {COLOR_W{bar_rgb[1]}};
          b_d = {COLOR_W{bar_rgb[0]}};
        end
        MODE_STREAM: begin
          if (bus.iPIX_VALID) begin
            r_d = bus.iPIX_R;
            g_d = bus.iPIX_G;
            b_d = bus.iPIX_B;
          end else begin
            uf_set = 1'b1;
          end
        end
        default: ; // blank: black
      endcase
    end
    // Sticky: a new underflow wins over a same-cycle clear.
    uf_d = uf_set | (uf_q & ~bus.iCLR_ERR);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      x_q    <= '0;
      y_q    <= '0;
      mode_q <= MODE_BLANK;
      hd_q   <= 1'b1;
      vd_q   <= 1'b1;
      de_q   <= 1'b0;
      uf_q   <= 1'b0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      mode_q <= mode_d;
      hd_q   <= hd_d;
      vd_q   <= vd_d;
      de_q   <= de_d;
      uf_q   <= uf_d;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
    end
  end

  // Requests for the next frame (lookahead wrapped past V_TOTAL) are only
  // issued when the stream mode is predicted to persist, i.e. iMODE is 3 now.
  assign bus.oREQ = ~iRST && (mode_q == MODE_STREAM) && is_active(la_x, la_y)
                    && (~la_next_frame || (bus.iMODE == MODE_STREAM));

  assign bus.oHD        = hd_q;
  assign bus.oVD        = vd_q;
  assign bus.oDE        = de_q;
  assign bus.oLCD_R     = r_q;
  assign bus.oLCD_G     = g_q;
  assign bus.oLCD_B     = b_q;
  assign bus.oUNDERFLOW = uf_q;
  assign bus.oX         = x_q;
  assign bus.oY         = y_q;
  assign bus.oNewFrame  = ~iRST && frame_start;
  assign bus.oEndFrame  = ~iRST && (x_q == X_EF) && (y_q == Y_EF);

endmodule

// File: tb/tb_mtl_timing_engine.sv
// tb_mtl_timing_engine: randomized self-checking bench for mtl_timing_engine using a
//   reduced raster (main instance) plus the 8/2/1/1, 4/1/1/1 small-timing instance.
// Reference model works from absolute cycle index since reset (x = p mod H_TOTAL, ...).
module tb_mtl_timing_engine;

  localparam int MHA = 83, MHF = 18, MHS = 1, MHB = 4;
  localparam int MVA = 24, MVF = 2,  MVS = 1, MVB = 2;
  localparam int LEAD = 2;
  localparam int HT  = MHS + MHB + MHA + MHF;   // 106
  localparam int VT  = MVS + MVB + MVA + MVF;   // 29
  localparam int FT  = HT * VT;
  localparam int HA0 = MHS + MHB;
  localparam int VA0 = MVS + MVB;

  typedef struct packed {
    logic       hd, vd, de;
    logic [7:0] r, g, b;
    logic       req, nf, ef, uf;
    logic [10:0] x;
    logic [9:0]  y;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mtl_timing_engine_if #(.COLOR_W(8)) bus   ();
  mtl_timing_engine_if #(.COLOR_W(8)) bus_s ();

  mtl_timing_engine #(
    .H_ACTIVE(MHA), .H_FP(MHF), .H_SYNC(MHS), .H_BP(MHB),
    .V_ACTIVE(MVA), .V_FP(MVF), .V_SYNC(MVS), .V_BP(MVB),
    .COLOR_W(8), .REQ_LEAD(LEAD)
  ) dut (.iCLK(clk), .iRST(rst), .bus(bus.master));

  mtl_timing_engine #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .COLOR_W(8), .REQ_LEAD(2)
  ) dut_s (.iCLK(clk), .iRST(rst), .bus(bus_s.master));

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int         p;
  logic [1:0] fm;
  logic       uf_m;
  logic [1:0] cur_mode;
  bit         force_invalid;
  bit         clr_now;
  bit         req_q[$];
  bit [2:0]   bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  function automatic bit m_active(int x, int y);
    return (x >= HA0) && (x < HA0 + MHA) && (y >= VA0) && (y < VA0 + MVA);
  endfunction

  task automatic model_reset();
    p = 0; fm = 2'd0; uf_m = 1'b0;
    req_q.delete();
    for (int i = 0; i < LEAD; i++) req_q.push_back(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cur_mode = 2'd0; force_invalid = 1'b0; clr_now = 1'b0;
    bus.iMODE = 2'd0; bus.iPIX_VALID = 1'b0; bus.iCLR_ERR = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Drives one pixel clock (acting as the stream source) and returns observed and
  // model-expected outputs for counter position p.
  task automatic run_cycle(output snap_t o, output snap_t e);
    int x, y, la, lx, ly, bar;
    bit la_nf, act, got_req;
    logic [7:0] sr, sg, sb, pr, pg, pb;
    logic set_uf;
    bit [2:0] rgb;
    x = p % HT; y = (p / HT) % VT;
    sr = 8'($urandom); sg = 8'($urandom); sb = 8'($urandom);
    pr = 8'(x); pg = 8'(y); pb = 8'($urandom);
    got_req = req_q.pop_front();
    bus.iMODE = cur_mode;
    bus.iSOLID_R = sr; bus.iSOLID_G = sg; bus.iSOLID_B = sb;
    bus.iPIX_R = pr; bus.iPIX_G = pg; bus.iPIX_B = pb;
    bus.iPIX_VALID = got_req && !force_invalid;
    bus.iCLR_ERR = clr_now;
    if (x == 0 && y == 0) fm = cur_mode;
    #1;
    o = '0; e = '0;
    o.x = bus.oX; o.y = bus.oY; o.nf = bus.oNewFrame; o.ef = bus.oEndFrame; o.req = bus.oREQ;
    req_q.push_back(bus.oREQ);
    e.x = 11'(x); e.y = 10'(y);
    e.nf = (x == 0 && y == 0);
    e.ef = (x == HA0 + MHA - 1) && (y == VA0 + MVA - 1);
    la = p + LEAD; lx = la % HT; ly = (la / HT) % VT; la_nf = (la / FT) != (p / FT);
    e.req = m_active(lx, ly) && (fm == 2'd3) && (!la_nf || cur_mode == 2'd3);
    act = m_active(x, y); set_uf = 1'b0;
    if (act) begin
      case (fm)
        2'd1: begin e.r = sr; e.g = sg; e.b = sb; end
        2'd2: begin
          bar = (x - HA0) / (MHA / 8);
          if (bar > 7) bar = 7;
          rgb = bar_tab[bar];
          e.r = {8{rgb[2]}}; e.g = {8{rgb[1]}}; e.b = {8{rgb[0]}};
        end
        2'd3: begin
          if (!force_invalid) begin e.r = pr; e.g = pg; e.b = pb; end
          else set_uf = 1'b1;
        end
        default: ;
      endcase
    end
    uf_m = set_uf | (uf_m & !clr_now);
    e.hd = (x >= MHS); e.vd = (y >= MVS); e.de = act; e.uf = uf_m;
    @(negedge clk);
    o.hd = bus.oHD; o.vd = bus.oVD; o.de = bus.oDE;
    o.r = bus.oLCD_R; o.g = bus.oLCD_G; o.b = bus.oLCD_B; o.uf = bus.oUNDERFLOW;
    p++;
  endtask

  task automatic test_reset();
    snap_t o, e;
    int stop;
    do_reset();
    cur_mode = 2'd3;
    stop = VA0 * HT + HA0 + 20;
    while (p < stop) begin
      force_invalid = (p == VA0 * HT + HA0 + 5);
      run_cycle(o, e);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL reset_pre p=%0d got=%h want=%h", p - 1, o, e); end
    end
    force_invalid = 1'b0;
    // Assert reset between edges; everything must be forced without a clock.
    @(posedge clk); #2; rst = 1'b1; #1;
    n_checks++;
    if ({bus.oHD, bus.oVD, bus.oDE, bus.oREQ, bus.oUNDERFLOW} !== 5'b11000) begin
      n_fail++; $display("FAIL reset_ctrl got=%b want=11000",
                         {bus.oHD, bus.oVD, bus.oDE, bus.oREQ, bus.oUNDERFLOW});
    end
    n_checks++;
    if ({bus.oLCD_R, bus.oLCD_G, bus.oLCD_B} !== 24'h0) begin
      n_fail++; $display("FAIL reset_lcd got=%h want=000000", {bus.oLCD_R, bus.oLCD_G, bus.oLCD_B});
    end
    n_checks++;
    if ({bus.oX, bus.oY} !== 21'h0) begin
      n_fail++; $display("FAIL reset_xy got=%0d,%0d want=0,0", bus.oX, bus.oY);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    cur_mode = 2'd1;
    // Fresh frame from x=0,y=0 with no trace of the aborted line.
    repeat (2 * HT) begin
      run_cycle(o, e);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL reset_post p=%0d got=%h want=%h", p - 1, o, e); end
    end
  endtask

  task automatic test_blank();
    snap_t o, e;
    int hd_lo = 0, vd_lo = 0, de_hi = 0, reqs = 0;
    do_reset();
    cur_mode = 2'd0;
    repeat (2 * FT) begin
      run_cycle(o, e);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL blank p=%0d got=%h want=%h", p - 1, o, e); end
      hd_lo += !o.hd; vd_lo += !o.vd; de_hi += o.de; reqs += o.req;
    end
    n_checks++;
    if (hd_lo !== 2 * VT * MHS) begin n_fail++; $display("FAIL blank_hd_low got=%0d want=%0d", hd_lo, 2 * VT * MHS); end
    n_checks++;
    if (vd_lo !== 2 * HT * MVS) begin n_fail++; $display("FAIL blank_vd_low got=%0d want=%0d", vd_lo, 2 * HT * MVS); end
    n_checks++;
    if (de_hi !== 2 * MHA * MVA) begin n_fail++; $display("FAIL blank_de got=%0d want=%0d", de_hi, 2 * MHA * MVA); end
    n_checks++;
    if (reqs !== 0) begin n_fail++; $display("FAIL blank_req got=%0d want=0", reqs); end
  endtask

  task automatic test_solid();
    snap_t o, e;
    do_reset();
    cur_mode = 2'd1;
    repeat (FT) begin
      run_cycle(o, e);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL solid p=%0d got=%h want=%h", p - 1, o, e); end
    end
  endtask

  task automatic test_bars();
    snap_t o, e;
    int         offs [5] = '{0, 10, 69, 75, 82};
    logic [23:0] cols [5] = '{24'hFFFFFF, 24'hFFFF00, 24'h0000FF, 24'h000000, 24'h000000};
    do_reset();
    cur_mode = 2'd2;
    repeat (FT) begin
      run_cycle(o, e);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL bars p=%0d got=%h want=%h", p - 1, o, e); end
      if (e.y == 10'(VA0)) begin
        for (int k = 0; k < 5; k++) begin
          if (e.x == 11'(HA0 + offs[k])) begin
            n_checks++;
            if ({o.r, o.g, o.b} !== cols[k]) begin
              n_fail++; $display("FAIL bars_px%0d got=%h want=%h", offs[k], {o.r, o.g, o.b}, cols[k]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_stream();
    snap_t o, e;
    int reqs = 0;
    do_reset();
    cur_mode = 2'd3;
    repeat (FT) begin
      run_cycle(o, e);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL stream p=%0d got=%h want=%h", p - 1, o, e); end
      reqs += o.req;
    end
    n_checks++;
    if (reqs !== MHA * MVA) begin n_fail++; $display("FAIL stream_reqs got=%0d want=%0d", reqs, MHA * MVA); end
    n_checks++;
    if (bus.oUNDERFLOW !== 1'b0) begin n_fail++; $display("FAIL stream_uf got=%b want=0", bus.oUNDERFLOW); end
  endtask

  task automatic test_underflow();
    snap_t o, e;
    int d1, d2, dc;
    do_reset();
    cur_mode = 2'd3;
    d1 = (VA0 + $urandom_range(0, 5)) * HT + HA0 + $urandom_range(0, MHA - 1);
    d2 = (VA0 + 10) * HT + HA0 + $urandom_range(0, MHA - 1);
    dc = (VA0 + 15) * HT;
    repeat (FT) begin
      force_invalid = (p == d1) || (p == d2);
      clr_now       = (p == d2) || (p == dc);
      run_cycle(o, e);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL underflow p=%0d got=%h want=%h", p - 1, o, e); end
      if (p - 1 == d1) begin
        n_checks++;
        if ({o.r, o.g, o.b, o.uf} !== 25'h1) begin
          n_fail++; $display("FAIL uf_drop got=%h/%b want=000000/1", {o.r, o.g, o.b}, o.uf);
        end
      end
      if (p - 1 == d2) begin
        n_checks++;
        if (o.uf !== 1'b1) begin n_fail++; $display("FAIL uf_set_vs_clr got=%b want=1", o.uf); end
      end
      if (p - 1 == dc) begin
        n_checks++;
        if (o.uf !== 1'b0) begin n_fail++; $display("FAIL uf_clear got=%b want=0", o.uf); end
      end
    end
    force_invalid = 1'b0; clr_now = 1'b0;
  endtask

  task automatic test_mode_switch();
    snap_t o, e;
    do_reset();
    cur_mode = 2'd1;
    repeat (2 * FT) begin
      if (p == 12 * HT) cur_mode = 2'd2;
      run_cycle(o, e);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL mode_switch p=%0d got=%h want=%h", p - 1, o, e); end
      if (p - 1 == FT + VA0 * HT + HA0) begin
        n_checks++;
        if ({o.r, o.g, o.b} !== 24'hFFFFFF) begin
          n_fail++; $display("FAIL switch_first_bar got=%h want=FFFFFF", {o.r, o.g, o.b});
        end
      end
    end
  endtask

  task automatic test_small();
    int ef_cnt = 0, xm, ym;
    bus_s.iMODE = 2'd0; bus_s.iCLR_ERR = 1'b0; bus_s.iPIX_VALID = 1'b0;
    do_reset();
    for (int c = 0; c < 2 * 12 * 7; c++) begin
      #1;
      xm = c % 12; ym = (c / 12) % 7;
      n_checks++;
      if ({bus_s.oX, bus_s.oY, bus_s.oEndFrame, bus_s.oNewFrame} !==
          {11'(xm), 10'(ym), (xm == 9 && ym == 5), (xm == 0 && ym == 0)}) begin
        n_fail++;
        $display("FAIL small c=%0d got x=%0d y=%0d ef=%b nf=%b want x=%0d y=%0d", c,
                 bus_s.oX, bus_s.oY, bus_s.oEndFrame, bus_s.oNewFrame, xm, ym);
      end
      ef_cnt += bus_s.oEndFrame;
      @(negedge clk);
    end
    n_checks++;
    if (ef_cnt !== 2) begin n_fail++; $display("FAIL small_ef_count got=%0d want=2", ef_cnt); end
  endtask

  initial begin
    bus.iMODE = 2'd0; bus.iSOLID_R = '0; bus.iSOLID_G = '0; bus.iSOLID_B = '0;
    bus.iPIX_R = '0; bus.iPIX_G = '0; bus.iPIX_B = '0; bus.iPIX_VALID = 1'b0; bus.iCLR_ERR = 1'b0;
    bus_s.iMODE = 2'd0; bus_s.iSOLID_R = '0; bus_s.iSOLID_G = '0; bus_s.iSOLID_B = '0;
    bus_s.iPIX_R = '0; bus_s.iPIX_G = '0; bus_s.iPIX_B = '0; bus_s.iPIX_VALID = 1'b0;
    bus_s.iCLR_ERR = 1'b0;
    test_reset();
    test_blank();
    test_solid();
    test_bars();
    test_stream();
    test_underflow();
    test_mode_switch();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
